// File: rtl/boot_shadow_sequencer.sv
// boot_shadow_sequencer
// Copies COPY_LEN bytes from boot EEPROM into RAM at power-up while holding
// the CPU in reset, keeps the CPU in reset for HOLD_CYCLES more clocks, then
// hands the bus to the CPU and decodes its address into device strobes.
//
// Ports
//   clock, reset_n          system clock, async active-low reset
//   cpu_address, cpu_rw     CPU address bus and read(1)/write(0)
//   copy_restart            one-clock pulse, re-runs the copy when in RUN
//   bus_address, bus_own    sequencer-driven address and bus ownership
//   cpu_be, cpu_res_n       CPU bus enable (~bus_own) and CPU reset (low)
//   ram_*/eeprom_*/via/acia active-low device strobes
//   busy, done              copy in progress / CPU running
//
// state | meaning
// SETUP | present address idx, EEPROM driving data
// WR_LO | RAM write strobe low
// WR_HI | write strobe released, address/data still held
// NEXT  | terminal compare on idx, else advance
// HOLD  | bus released, CPU still in reset for HOLD_CYCLES clocks
// RUN   | CPU running, address decode active
module boot_shadow_sequencer #(
  parameter int COPY_LEN    = 8192,
  parameter int HOLD_CYCLES = 4,
  parameter bit SHADOW_WP   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_rw,
  input  logic        copy_restart,
  output logic [15:0] bus_address,
  output logic        bus_own,
  output logic        cpu_be,
  output logic        cpu_res_n,
  output logic        ram_cs_n,
  output logic        ram_we_n,
  output logic        ram_oe_n,
  output logic        eeprom_cs_n,
  output logic        eeprom_oe_n,
  output logic        via_ce_n,
  output logic        acia_ce_n,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    SETUP = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    NEXT  = 3'd3,
    HOLD  = 3'd4,
    RUN   = 3'd5
  } state_e;

  localparam logic [12:0] IDX_LAST  = 13'(COPY_LEN - 1);
  localparam logic [7:0]  HCNT_LAST = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [12:0] idx_q, idx_d;
  logic [7:0]  hcnt_q, hcnt_d;

  logic in_shadow, sel_ram, sel_via, sel_acia;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SETUP;
      idx_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Terminal compare happens before the increment, so idx never wraps.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      SETUP: state_d = WR_LO;
      WR_LO: state_d = WR_HI;
      WR_HI: state_d = NEXT;
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + 13'd1;
        end
      end
      HOLD: begin
        hcnt_d = hcnt_q + 8'd1;
        if (hcnt_q == HCNT_LAST) state_d = RUN;
      end
      RUN: begin
        if (copy_restart) begin
          state_d = SETUP;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = SETUP;
        idx_d   = '0;
      end
    endcase
  end

  assign in_shadow = (cpu_address[15:13] == 3'b111);
  assign sel_ram   = ~cpu_address[15] | in_shadow;
  assign sel_via   = (cpu_address[15:12] == 4'h8);
  assign sel_acia  = (cpu_address[15:12] == 4'h9);

  always_comb begin
    bus_address = 16'h0000;
    bus_own     = 1'b0;
    cpu_res_n   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    ram_cs_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_oe_n    = 1'b1;
    eeprom_cs_n = 1'b1;
    eeprom_oe_n = 1'b1;
    via_ce_n    = 1'b1;
    acia_ce_n   = 1'b1;
    case (state_q)
      SETUP, WR_LO, WR_HI, NEXT: begin
        bus_own     = 1'b1;
        busy        = 1'b1;
        bus_address = {3'b000, idx_q};
        eeprom_cs_n = 1'b0;
        eeprom_oe_n = 1'b0;
        ram_cs_n    = 1'b0;
        ram_we_n    = (state_q != WR_LO);
      end
      RUN: begin
        cpu_res_n = 1'b1;
        done      = 1'b1;
        via_ce_n  = ~sel_via;
        acia_ce_n = ~sel_acia;
        if (sel_ram) begin
          ram_cs_n = 1'b0;
          ram_oe_n = ~cpu_rw;
          // Shadowed boot image is read-only to the CPU when protected.
          ram_we_n = cpu_rw | (SHADOW_WP & in_shadow);
        end
      end
      default: ;
    endcase
  end

  assign cpu_be = ~bus_own;

endmodule

// File: tb/tb_boot_shadow_sequencer.sv
module tb_boot_shadow_sequencer;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_address;
  logic        cpu_rw;
  logic        copy_restart;

  logic [15:0] s_bus_address, f_bus_address;
  logic s_bus_own, s_cpu_be, s_cpu_res_n, s_ram_cs_n, s_ram_we_n, s_ram_oe_n;
  logic s_eeprom_cs_n, s_eeprom_oe_n, s_via_ce_n, s_acia_ce_n, s_busy, s_done;
  logic f_bus_own, f_cpu_be, f_cpu_res_n, f_ram_cs_n, f_ram_we_n, f_ram_oe_n;
  logic f_eeprom_cs_n, f_eeprom_oe_n, f_via_ce_n, f_acia_ce_n, f_busy, f_done;

  always #5 clock = ~clock;

  boot_shadow_sequencer #(.COPY_LEN(4), .HOLD_CYCLES(4), .SHADOW_WP(1'b1)) dut_s (
    .clock(clock), .reset_n(rst_n), .cpu_address(cpu_address), .cpu_rw(cpu_rw),
    .copy_restart(copy_restart), .bus_address(s_bus_address), .bus_own(s_bus_own),
    .cpu_be(s_cpu_be), .cpu_res_n(s_cpu_res_n), .ram_cs_n(s_ram_cs_n),
    .ram_we_n(s_ram_we_n), .ram_oe_n(s_ram_oe_n), .eeprom_cs_n(s_eeprom_cs_n),
    .eeprom_oe_n(s_eeprom_oe_n), .via_ce_n(s_via_ce_n), .acia_ce_n(s_acia_ce_n),
    .busy(s_busy), .done(s_done));

  boot_shadow_sequencer dut_f (
    .clock(clock), .reset_n(rst_n), .cpu_address(cpu_address), .cpu_rw(cpu_rw),
    .copy_restart(copy_restart), .bus_address(f_bus_address), .bus_own(f_bus_own),
    .cpu_be(f_cpu_be), .cpu_res_n(f_cpu_res_n), .ram_cs_n(f_ram_cs_n),
    .ram_we_n(f_ram_we_n), .ram_oe_n(f_ram_oe_n), .eeprom_cs_n(f_eeprom_cs_n),
    .eeprom_oe_n(f_eeprom_oe_n), .via_ce_n(f_via_ce_n), .acia_ce_n(f_acia_ce_n),
    .busy(f_busy), .done(f_done));

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_f[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  bit   mon_s_en = 1'b1;
  int   f_pulses;
  logic [15:0] f_max_addr;
  logic [15:0] f_last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edge number since the last reset release.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard: every RAM write strobe seen must match the next expected write.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      f_pulses   = 0;
      f_max_addr = 16'h0000;
    end else begin
      if (mon_s_en && s_ram_we_n == 1'b0) begin
        if (q_s.size() == 0) chk("s_extra_we", 32'd1, 32'd0);
        else begin
          e = q_s.pop_front();
          chk("s_we_addr", {16'h0, s_bus_address}, {16'h0, e.addr});
          chk("s_we_cyc", cyc, e.cyc);
        end
      end
      if (f_bus_own && f_bus_address > f_max_addr) f_max_addr = f_bus_address;
      if (f_ram_we_n == 1'b0) begin
        f_pulses++;
        f_last_addr = f_bus_address;
        if (q_f.size() == 0) chk("f_extra_we", 32'd1, 32'd0);
        else begin
          e = q_f.pop_front();
          chk("f_we_addr", {16'h0, f_bus_address}, {16'h0, e.addr});
          chk("f_we_cyc", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push_copy(input int base);
    for (int i = 0; i < 4; i++) q_s.push_back('{addr: 16'(i), cyc: base + 1 + 4 * i});
  endtask

  task automatic release_reset();
    @(negedge clock);
    push_copy(0);
    for (int i = 0; i < 8192; i++) q_f.push_back('{addr: 16'(i), cyc: 1 + 4 * i});
    rst_n = 1'b1;
  endtask

  // base = edge on which SETUP with idx 0 is entered.
  task automatic wait_run(input string tag, input int base);
    int hold_cyc = -1;
    int run_cyc  = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (hold_cyc < 0 && !s_busy && !s_cpu_res_n) hold_cyc = cyc;
      if (s_cpu_res_n) begin
        run_cyc = cyc;
        break;
      end
    end
    chk({tag, "_hold_cyc"}, hold_cyc, base + 16);
    chk({tag, "_run_cyc"}, run_cyc, base + 20);
    chk({tag, "_done"}, {31'd0, s_done}, 32'd1);
    chk({tag, "_q_empty"}, q_s.size(), 32'd0);
  endtask

  task automatic run_decode(input string tag, input logic [15:0] a, input logic rw,
                            input logic [6:0] exp);
    @(negedge clock);
    cpu_address = a;
    cpu_rw      = rw;
    #1;
    // {ram_cs, ram_we, ram_oe, via, acia, eeprom_cs, eeprom_oe}
    chk(tag, {25'd0, s_ram_cs_n, s_ram_we_n, s_ram_oe_n, s_via_ce_n, s_acia_ce_n,
              s_eeprom_cs_n, s_eeprom_oe_n}, {25'd0, exp});
  endtask

  initial begin
    int base;
    bit found;
    rst_n        = 1'b0;
    cpu_address  = 16'h0000;
    cpu_rw       = 1'b1;
    copy_restart = 1'b0;
    repeat (3) @(negedge clock);

    // {bus_own, cpu_res_n, ram_we_n, busy, done, cpu_be}
    chk("rst_s_ctl", {26'd0, s_bus_own, s_cpu_res_n, s_ram_we_n, s_busy, s_done, s_cpu_be},
        32'b101100);
    chk("rst_f_ctl", {26'd0, f_bus_own, f_cpu_res_n, f_ram_we_n, f_busy, f_done, f_cpu_be},
        32'b101100);
    chk("rst_s_addr", {16'h0, s_bus_address}, 32'h0);

    release_reset();
    wait_run("boot", 0);
    chk("run_bus_addr", {16'h0, s_bus_address}, 32'h0);
    chk("run_bus_own", {30'd0, s_bus_own, s_cpu_be}, 32'b01);

    mon_s_en = 1'b0;
    run_decode("dec_0000", 16'h0000, 1'b1, 7'b0101111);
    run_decode("dec_8005", 16'h8005, 1'b1, 7'b1110111);
    run_decode("dec_9001", 16'h9001, 1'b1, 7'b1111011);
    run_decode("dec_b000", 16'hB000, 1'b1, 7'b1111111);
    run_decode("dec_f000", 16'hF000, 1'b1, 7'b0101111);
    run_decode("wr_f000_wp", 16'hF000, 1'b0, 7'b0111111);
    run_decode("wr_1000", 16'h1000, 1'b0, 7'b0011111);
    @(negedge clock);
    cpu_rw      = 1'b1;
    cpu_address = 16'h0000;
    mon_s_en    = 1'b1;

    // Restart from RUN; full DUT is mid-copy and must ignore the pulse.
    @(negedge clock);
    base = cyc + 1;
    push_copy(base);
    copy_restart = 1'b1;
    @(posedge clock);
    #1;
    chk("rs_ctl", {28'd0, s_bus_own, s_cpu_res_n, s_busy, s_done}, 32'b1010);
    chk("rs_addr", {16'h0, s_bus_address}, 32'h0);
    @(negedge clock);
    copy_restart = 1'b0;
    @(negedge clock);
    copy_restart = 1'b1;
    @(negedge clock);
    copy_restart = 1'b0;
    wait_run("restart", base);

    // Reset the long copy in the middle of writing byte 0x0123.
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #1;
      if (f_bus_address == 16'h0123 && !f_ram_we_n) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_found", {31'd0, found}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_we_n", {31'd0, f_ram_we_n}, 32'd1);
    chk("mid_addr", {16'h0, f_bus_address}, 32'h0);
    chk("mid_own", {31'd0, f_bus_own}, 32'd1);
    q_f.delete();
    q_s.delete();
    repeat (2) @(negedge clock);
    release_reset();
    wait_run("rerun", 0);

    found = 1'b0;
    for (int i = 0; i < 33000; i++) begin
      @(posedge clock);
      #1;
      if (f_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("full_done", {31'd0, found}, 32'd1);
    chk("full_done_cyc", cyc, 32'd32772);
    chk("full_pulses", f_pulses, 32'd8192);
    chk("full_last_addr", {16'h0, f_last_addr}, 32'h1FFF);
    chk("full_max_addr", {16'h0, f_max_addr}, 32'h1FFF);
    chk("full_q_empty", q_f.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
